// File: rtl/button_control_interface.sv
// button_control_interface: debounces clip/mode/go buttons and sequences record/play sessions.
module button_control_interface #(
    parameter int CNT_W = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter int LEN_W = 32,
    parameter logic [LEN_W-1:0] MAX_CLIP_CYCLES = 32'd400000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_clip,
    input  logic             btn_mode,
    input  logic             btn_go,
    input  logic             play_done,
    output logic             clipNum,
    output logic             recordOrPlay,
    output logic             active,
    output logic             start_pulse,
    output logic             stop_pulse,
    output logic [LEN_W-1:0] session_len
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - 1'b1;
    localparam logic [LEN_W-1:0] LEN_LAST = MAX_CLIP_CYCLES - 1'b1;
    state_t state;
    logic [2:0] raw, sync1, sync2, level, level_d, press;
    logic [CNT_W-1:0] cnt [3];
    logic stop;
    assign raw = {btn_go, btn_mode, btn_clip};
    // bit 0 clip, bit 1 mode, bit 2 go; press is a registered rising edge of the debounced level
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            level_d <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            level_d <= level;
            press <= level & ~level_d;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= (sync2[i] != level[i] && cnt[i] != DB_LAST) ? cnt[i] + 1'b1 : '0;
                if (sync2[i] != level[i] && cnt[i] == DB_LAST) level[i] <= sync2[i];
            end
        end
    assign stop = press[2] || session_len == LEN_LAST || (recordOrPlay && play_done);
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            clipNum <= 1'b0;
            recordOrPlay <= 1'b0;
            active <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse <= 1'b0;
            session_len <= '0;
        end else begin
            start_pulse <= 1'b0;
            stop_pulse <= 1'b0;
            if (state == IDLE) begin
                clipNum <= clipNum ^ press[0];
                recordOrPlay <= recordOrPlay ^ press[1];
                if (press[2]) begin
                    state <= RUN;
                    active <= 1'b1;
                    start_pulse <= 1'b1;
                    session_len <= '0;
                end
            end else if (stop) begin
                state <= IDLE;
                active <= 1'b0;
                stop_pulse <= 1'b1;
            end else if (session_len != MAX_CLIP_CYCLES) begin
                session_len <= session_len + 1'b1;
            end
        end
endmodule

// File: tb/tb_button_control_interface.sv
// tb_button_control_interface: table, directed and random checks against a window-based reference model.
module tb_button_control_interface;
    localparam int DB = 4;
    localparam int MAXC = 50;
    logic clock = 1'b0, reset = 1'b0;
    logic btn_clip = 1'b0, btn_mode = 1'b0, btn_go = 1'b0, play_done = 1'b0;
    logic clipNum, recordOrPlay, active, start_pulse, stop_pulse;
    logic [31:0] session_len;
    int vectors = 0, miscompares = 0;
    bit chk_en = 1'b0;

    button_control_interface #(.DEBOUNCE_CYCLES(20'd4), .MAX_CLIP_CYCLES(32'd50)) dut (
        .clock(clock), .reset(reset), .btn_clip(btn_clip), .btn_mode(btn_mode), .btn_go(btn_go),
        .play_done(play_done), .clipNum(clipNum), .recordOrPlay(recordOrPlay), .active(active),
        .start_pulse(start_pulse), .stop_pulse(stop_pulse), .session_len(session_len)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a level flips once the last DB raw samples (seen through the
    // 2-cycle synchronizer) all disagree with it; the FSM sees a rise two edges later.
    logic [2:0] raw_q[$];
    bit [2:0] mlev = 0, r1 = 0, r2 = 0, p, rise;
    bit m_run = 0, m_clip = 0, m_rop = 0, m_start = 0, m_stop = 0;
    int m_len = 0, differ;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            raw_q.delete();
            mlev = 0; r1 = 0; r2 = 0;
            m_run = 0; m_clip = 0; m_rop = 0; m_start = 0; m_stop = 0; m_len = 0;
        end else begin
            p = r2;
            r2 = r1;
            rise = 0;
            raw_q.push_back({btn_go, btn_mode, btn_clip});
            if (raw_q.size() > DB + 2) raw_q.delete(0);
            if (raw_q.size() == DB + 2)
                for (int b = 0; b < 3; b++) begin
                    differ = 0;
                    for (int k = 0; k < DB; k++) if (raw_q[k][b] != mlev[b]) differ++;
                    if (differ == DB) begin
                        mlev[b] = !mlev[b];
                        rise[b] = mlev[b];
                    end
                end
            r1 = rise;
            m_start = 0;
            m_stop = 0;
            if (!m_run) begin
                m_clip = m_clip ^ p[0];
                m_rop = m_rop ^ p[1];
                if (p[2]) begin m_run = 1; m_start = 1; m_len = 0; end
            end else if (p[2] || m_len == MAXC - 1 || (m_rop && play_done)) begin
                m_run = 0;
                m_stop = 1;
            end else if (m_len < MAXC) m_len++;
        end
    end

    always @(negedge clock)
        if (chk_en) begin
            chk("model clipNum", clipNum, m_clip);
            chk("model recordOrPlay", recordOrPlay, m_rop);
            chk("model active", active, m_run);
            chk("model start_pulse", start_pulse, m_start);
            chk("model stop_pulse", stop_pulse, m_stop);
            chk("model session_len", session_len, m_len);
            chk("start/stop overlap", start_pulse & stop_pulse, 0);
        end

    task automatic press(input logic [2:0] m);
        {btn_go, btn_mode, btn_clip} = m;
        repeat (5) @(negedge clock);
        {btn_go, btn_mode, btn_clip} = 3'b000;
        repeat (5) @(negedge clock);
    endtask

    task automatic all_zero(input string name);
        chk({name, " clipNum"}, clipNum, 0);
        chk({name, " recordOrPlay"}, recordOrPlay, 0);
        chk({name, " active"}, active, 0);
        chk({name, " start_pulse"}, start_pulse, 0);
        chk({name, " stop_pulse"}, stop_pulse, 0);
        chk({name, " session_len"}, session_len, 0);
    endtask

    typedef struct {logic [2:0] btn; logic clip, rop, act;} vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0] = '{3'b001, 1, 0, 0};
        tbl[1] = '{3'b010, 1, 1, 0};
        tbl[2] = '{3'b011, 0, 0, 0};
        tbl[3] = '{3'b010, 0, 1, 0};
        tbl[4] = '{3'b010, 0, 0, 0};
        tbl[5] = '{3'b100, 0, 0, 1};
        tbl[6] = '{3'b011, 0, 0, 1};
        tbl[7] = '{3'b001, 0, 0, 1};
        tbl[8] = '{3'b100, 0, 0, 0};
        tbl[9] = '{3'b111, 1, 1, 1};
        tbl[10] = '{3'b100, 1, 1, 0};
        // reset with bouncing buttons
        @(posedge clock);
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clock);
            {btn_go, btn_mode, btn_clip} = 3'($urandom_range(0, 7));
        end
        all_zero("in reset");
        {btn_go, btn_mode, btn_clip} = 3'b000;
        #2 reset = 1'b1;
        repeat (8) @(negedge clock);
        all_zero("after reset");
        // glitch of 3 synced cycles is rejected
        btn_clip = 1'b1;
        repeat (3) @(negedge clock);
        btn_clip = 1'b0;
        repeat (10) @(negedge clock);
        chk("glitch clipNum", clipNum, 0);
        // clean press: clipNum flips on the 8th edge after the button is first sampled
        btn_clip = 1'b1;
        repeat (7) @(negedge clock);
        chk("latency-1 clipNum", clipNum, 0);
        @(negedge clock);
        chk("latency clipNum", clipNum, 1);
        repeat (2) @(negedge clock);
        btn_clip = 1'b0;
        repeat (10) @(negedge clock);
        chk("held clipNum", clipNum, 1);
        press(3'b001);
        chk("second press clipNum", clipNum, 0);
        // table of presses, including a record session and same-cycle events
        for (int i = 0; i < 11; i++) begin
            press(tbl[i].btn);
            chk($sformatf("tbl[%0d] clipNum", i), clipNum, tbl[i].clip);
            chk($sformatf("tbl[%0d] recordOrPlay", i), recordOrPlay, tbl[i].rop);
            chk($sformatf("tbl[%0d] active", i), active, tbl[i].act);
            if (i == 8) chk("tbl[8] session_len", session_len, 29);
        end
        // auto-stop of a record session; play_done ignored while recording
        press(3'b010);
        chk("to record", recordOrPlay, 0);
        press(3'b100);
        play_done = 1'b1;
        @(negedge clock);
        play_done = 1'b0;
        @(negedge clock);
        chk("record ignores play_done", active, 1);
        for (int i = 0; i < 100 && !stop_pulse; i++) @(negedge clock);
        chk("auto-stop stop_pulse", stop_pulse, 1);
        chk("auto-stop session_len", session_len, MAXC - 1);
        chk("auto-stop active", active, 0);
        repeat (5) @(negedge clock);
        chk("auto-stop len held", session_len, MAXC - 1);
        // play session ended by play_done
        press(3'b010);
        chk("to play", recordOrPlay, 1);
        press(3'b100);
        for (int i = 0; i < 100 && session_len != 20; i++) @(negedge clock);
        chk("play len reach 20", session_len, 20);
        play_done = 1'b1;
        @(negedge clock);
        play_done = 1'b0;
        chk("play_done stop_pulse", stop_pulse, 1);
        chk("play_done session_len", session_len, 20);
        chk("play_done active", active, 0);
        play_done = 1'b1;
        @(negedge clock);
        play_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle play_done active", active, 0);
        chk("idle play_done len", session_len, 20);
        // reset mid-session
        press(3'b100);
        for (int i = 0; i < 100 && session_len != 30; i++) @(negedge clock);
        chk("mid len reach 30", session_len, 30);
        #2 reset = 1'b0;
        #1 all_zero("mid-session reset");
        repeat (2) @(negedge clock);
        all_zero("mid-session reset held");
        #2 reset = 1'b1;
        // random buttons and play_done against the model
        for (int s = 0; s < 200; s++) begin
            {btn_go, btn_mode, btn_clip} = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 12)) begin
                play_done = ($urandom_range(0, 15) == 0);
                @(negedge clock);
            end
        end
        {btn_go, btn_mode, btn_clip} = 3'b000;
        play_done = 1'b0;
        repeat (10) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
